uart_mmio_port: RTL



---
 rtl/uart_mmio_port.sv | 326 ++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_mmio_port.sv
// uart_mmio_port: memory-mapped 8N1 UART with a TX holding register, RX FIFO and status register.
// Define UART_LOOPBACK_EN to add an internal TX->RX loopback controlled from the STATUS address.

module uart_mmio_port #(
   parameter int CLK_FREQ = 25000000,
   parameter int BAUD     = 115200,
   parameter int FIFO_AW  = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        bus_ce_i,
   input  logic        bus_we_i,
   input  logic        bus_addr_i,
   input  logic [7:0]  bus_data_i,
   output logic [31:0] bus_data_o,
   input  logic        rxd,
   output logic        txd,
   output logic        rx_int_o
);

   localparam int DIV   = (CLK_FREQ + BAUD / 2) / BAUD;
   localparam int CW    = (DIV > 2) ? $clog2(DIV) : 1;
   localparam int PW    = FIFO_AW + 1;
   localparam int DEPTH = 2 ** FIFO_AW;
   localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);
   localparam logic [CW-1:0] HALF_M1 = CW'(DIV / 2 - 1);

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_e;

   // bus access tracking
   logic rd_lvl, wr_lvl;
   logic rd_lvl_q, rd_lvl_d, wr_lvl_q, wr_lvl_d;
   logic rd_stb_q, rd_stb_d, wr_stb_q, wr_stb_d;
   logic acc_addr_q, acc_addr_d;
   logic [7:0] wr_data_q, wr_data_d;

   // transmitter
   uart_state_e tx_state_q, tx_state_d;
   logic [CW-1:0] tx_cnt_q, tx_cnt_d;
   logic [2:0]    tx_bit_q, tx_bit_d;
   logic [7:0]    tx_shift_q, tx_shift_d;
   logic          hold_full_q, hold_full_d;
   logic [7:0]    hold_data_q, hold_data_d;
   logic          tx_line, tx_busy, tx_ovr_set;

   // receiver
   logic rx_sync1_q, rx_sync1_d, rx_sync2_q, rx_sync2_d;
   logic rx_prev_q, rx_prev_d, rx_in;
   uart_state_e rx_state_q, rx_state_d;
   logic          rx_hunt_q, rx_hunt_d;
   logic [CW-1:0] rx_cnt_q, rx_cnt_d;
   logic [2:0]    rx_bit_q, rx_bit_d;
   logic [7:0]    rx_shift_q, rx_shift_d;
   logic          rx_push, frm_set;

   // FIFO and flags
   logic [7:0]    fifo_mem [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic          fifo_empty, fifo_full, fifo_pop, push_ok, rx_ovr_set, stat_clr;
   logic          rx_ovr_q, rx_ovr_d, frm_err_q, frm_err_d, tx_ovr_q, tx_ovr_d;
   logic          rx_int_q, rx_int_d;
   logic          lb_en;
   logic [31:0]   status;

`ifdef UART_LOOPBACK_EN
   logic lb_en_q, lb_en_d;

   always_comb begin
      lb_en_d = lb_en_q;
      if (wr_stb_q && acc_addr_q) lb_en_d = wr_data_q[0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) lb_en_q <= 1'b0;
      else        lb_en_q <= lb_en_d;
   end

   assign lb_en = lb_en_q;
`else
   assign lb_en = 1'b0;
`endif

   assign rd_lvl = bus_ce_i & ~bus_we_i;
   assign wr_lvl = bus_ce_i & bus_we_i;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      rd_lvl_d   = rd_lvl;
      wr_lvl_d   = wr_lvl;
      rd_stb_d   = rd_lvl & ~rd_lvl_q;
      wr_stb_d   = wr_lvl & ~wr_lvl_q;
      acc_addr_d = (rd_stb_d | wr_stb_d) ? bus_addr_i : acc_addr_q;
      wr_data_d  = wr_stb_d ? bus_data_i : wr_data_q;
   end

   always_comb begin
      tx_state_d  = tx_state_q;
      tx_cnt_d    = tx_cnt_q;
      tx_bit_d    = tx_bit_q;
      tx_shift_d  = tx_shift_q;
      hold_full_d = hold_full_q;
      hold_data_d = hold_data_q;
      tx_ovr_set  = 1'b0;

      if (wr_stb_q && !acc_addr_q) begin
         if (!hold_full_q) begin
            hold_full_d = 1'b1;
            hold_data_d = wr_data_q;
         end else begin
            tx_ovr_set = 1'b1;
         end
      end

      unique case (tx_state_q)
         S_IDLE: begin
            if (hold_full_q) begin
               tx_shift_d  = hold_data_q;
               hold_full_d = 1'b0;
               tx_cnt_d    = '0;
               tx_state_d  = S_START;
            end
         end
         S_START: begin
            if (tx_cnt_q == DIV_M1) begin
               tx_cnt_d   = '0;
               tx_bit_d   = '0;
               tx_state_d = S_DATA;
            end else begin
               tx_cnt_d = tx_cnt_q + 1'b1;
            end
         end
         S_DATA: begin
            if (tx_cnt_q == DIV_M1) begin
               tx_cnt_d   = '0;
               tx_shift_d = {1'b0, tx_shift_q[7:1]};
               tx_bit_d   = tx_bit_q + 1'b1;
               if (tx_bit_q == 3'd7) tx_state_d = S_STOP;
            end else begin
               tx_cnt_d = tx_cnt_q + 1'b1;
            end
         end
         S_STOP: begin
            if (tx_cnt_q == DIV_M1) begin
               tx_cnt_d = '0;
               // chain straight into the next start bit so queued bytes leave no idle gap
               if (hold_full_q) begin
                  tx_shift_d  = hold_data_q;
                  hold_full_d = 1'b0;
                  tx_state_d  = S_START;
               end else begin
                  tx_state_d = S_IDLE;
               end
            end else begin
               tx_cnt_d = tx_cnt_q + 1'b1;
            end
         end
         default: tx_state_d = S_IDLE;
      endcase
   end

   always_comb begin
      tx_line = 1'b1;
      if (tx_state_q == S_START)     tx_line = 1'b0;
      else if (tx_state_q == S_DATA) tx_line = tx_shift_q[0];
   end

   assign tx_busy = (tx_state_q != S_IDLE);
   assign txd     = lb_en | tx_line;
   assign rx_in   = lb_en ? tx_line : rx_sync2_q;

   always_comb begin
      rx_sync1_d = rxd;
      rx_sync2_d = rx_sync1_q;
      rx_prev_d  = rx_in;
      rx_state_d = rx_state_q;
      rx_hunt_d  = rx_hunt_q;
      rx_cnt_d   = rx_cnt_q;
      rx_bit_d   = rx_bit_q;
      rx_shift_d = rx_shift_q;
      rx_push    = 1'b0;
      frm_set    = 1'b0;

      unique case (rx_state_q)
         S_IDLE: begin
            if (rx_hunt_q) begin
               // half-bit qualification rejects short glitches on the line
               if (rx_cnt_q == HALF_M1) begin
                  rx_hunt_d = 1'b0;
                  rx_cnt_d  = '0;
                  if (!rx_in) rx_state_d = S_START;
               end else begin
                  rx_cnt_d = rx_cnt_q + 1'b1;
               end
            end else if (rx_prev_q && !rx_in) begin
               rx_hunt_d = 1'b1;
               rx_cnt_d  = '0;
            end
         end
         S_START: begin
            if (rx_cnt_q == DIV_M1) begin
               rx_cnt_d   = '0;
               rx_bit_d   = '0;
               rx_shift_d = {rx_in, rx_shift_q[7:1]};
               rx_state_d = S_DATA;
            end else begin
               rx_cnt_d = rx_cnt_q + 1'b1;
            end
         end
         S_DATA: begin
            if (rx_cnt_q == DIV_M1) begin
               rx_cnt_d   = '0;
               rx_shift_d = {rx_in, rx_shift_q[7:1]};
               rx_bit_d   = rx_bit_q + 1'b1;
               if (rx_bit_q == 3'd6) rx_state_d = S_STOP;
            end else begin
               rx_cnt_d = rx_cnt_q + 1'b1;
            end
         end
         S_STOP: begin
            if (rx_cnt_q == DIV_M1) begin
               rx_cnt_d   = '0;
               rx_state_d = S_IDLE;
               if (rx_in) rx_push = 1'b1;
               else       frm_set = 1'b1;
            end else begin
               rx_cnt_d = rx_cnt_q + 1'b1;
            end
         end
         default: rx_state_d = S_IDLE;
      endcase
   end

   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign fifo_full  = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                       (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);

   always_comb begin
      fifo_pop   = rd_stb_q & ~acc_addr_q & ~fifo_empty;
      push_ok    = rx_push & (~fifo_full | fifo_pop);
      rx_ovr_set = rx_push & fifo_full & ~fifo_pop;
      wr_ptr_d   = wr_ptr_q + PW'(push_ok);
      rd_ptr_d   = rd_ptr_q + PW'(fifo_pop);
      rx_int_d   = (wr_ptr_d != rd_ptr_d);
      stat_clr   = rd_stb_q & acc_addr_q;
      rx_ovr_d   = (rx_ovr_q  & ~stat_clr) | rx_ovr_set;
      frm_err_d  = (frm_err_q & ~stat_clr) | frm_set;
      tx_ovr_d   = (tx_ovr_q  & ~stat_clr) | tx_ovr_set;
   end

   // NOTE: FIFO storage is deliberately not reset; the pointers alone define what is valid.
   always_ff @(posedge clk) begin
      if (push_ok) fifo_mem[wr_ptr_q[FIFO_AW-1:0]] <= rx_shift_q;
   end

   assign status = {25'b0, lb_en, tx_busy, tx_ovr_q, frm_err_q, rx_ovr_q, ~fifo_empty, ~hold_full_q};

   always_comb begin
      bus_data_o = '0;
      if (rd_lvl) begin
         if (bus_addr_i)       bus_data_o = status;
         else if (!fifo_empty) bus_data_o = {24'b0, fifo_mem[rd_ptr_q[FIFO_AW-1:0]]};
      end
   end

   assign rx_int_o = rx_int_q;

   // NOTE: state registers use non-blocking assignments only, so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_lvl_q    <= 1'b0;
         wr_lvl_q    <= 1'b0;
         rd_stb_q    <= 1'b0;
         wr_stb_q    <= 1'b0;
         acc_addr_q  <= 1'b0;
         wr_data_q   <= '0;
         tx_state_q  <= S_IDLE;
         tx_cnt_q    <= '0;
         tx_bit_q    <= '0;
         tx_shift_q  <= '0;
         hold_full_q <= 1'b0;
         hold_data_q <= '0;
         rx_sync1_q  <= 1'b1;
         rx_sync2_q  <= 1'b1;
         rx_prev_q   <= 1'b1;
         rx_state_q  <= S_IDLE;
         rx_hunt_q   <= 1'b0;
         rx_cnt_q    <= '0;
         rx_bit_q    <= '0;
         rx_shift_q  <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         rx_ovr_q    <= 1'b0;
         frm_err_q   <= 1'b0;
         tx_ovr_q    <= 1'b0;
         rx_int_q    <= 1'b0;
      end else begin
         rd_lvl_q    <= rd_lvl_d;
         wr_lvl_q    <= wr_lvl_d;
         rd_stb_q    <= rd_stb_d;
         wr_stb_q    <= wr_stb_d;
         acc_addr_q  <= acc_addr_d;
         wr_data_q   <= wr_data_d;
         tx_state_q  <= tx_state_d;
         tx_cnt_q    <= tx_cnt_d;
         tx_bit_q    <= tx_bit_d;
         tx_shift_q  <= tx_shift_d;
         hold_full_q <= hold_full_d;
         hold_data_q <= hold_data_d;
         rx_sync1_q  <= rx_sync1_d;
         rx_sync2_q  <= rx_sync2_d;
         rx_prev_q   <= rx_prev_d;
         rx_state_q  <= rx_state_d;
         rx_hunt_q   <= rx_hunt_d;
         rx_cnt_q    <= rx_cnt_d;
         rx_bit_q    <= rx_bit_d;
         rx_shift_q  <= rx_shift_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         rx_ovr_q    <= rx_ovr_d;
         frm_err_q   <= frm_err_d;
         tx_ovr_q    <= tx_ovr_d;
         rx_int_q    <= rx_int_d;
      end
   end

endmodule
